i2c_slave_responder: RTL and testbench

- I2C target (responder) for the opposite end of the bus from the APB I2C master; used as the bench-side and on-chip peer for master write/read traffic.
- Watches scl/sda, detects START/STOP, matches a 7-bit address, ACKs, and stores written bytes in a small internal register file. Returns bytes from that file on reads.
- Single clock domain (PCLK); bus inputs are asynchronous and are synchronized internally. Open-drain drive through sda_oe.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_slave_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    // Protocol FSM states.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WR_PTR,
        WR_BYTE,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    // Sub-phase used around the 9th clock of a byte.
    //   AP_NONE  : shifting data bits
    //   AP_ARM   : byte done, pull SDA at the next SCL fall
    //   AP_DRIVE : holding SDA low, release at the next SCL fall
    //   AP_MACK  : master ACKed a read byte, load the next one at the next fall
    typedef enum logic [1:0] {
        AP_NONE,
        AP_ARM,
        AP_DRIVE,
        AP_MACK
    } ack_phase_e;

    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h10;
    localparam int         DEPTH_DEFAULT      = 16;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers on SCL/SDA plus a registered copy for edge and
// START/STOP detection. All detect outputs are combinational from the
// synchronized stage, so the FSM acts on the third PCLK after a bus change.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    // Synchronizer chains; idle bus level is high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & ~sda_prev_q & sda_sync_q;
    assign sda_s     = sda_sync_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a small byte-wide register file. Write traffic sets a
// pointer then auto-increments through the file; reads stream from the
// pointer until the master NACKs.
//
//  state    | meaning
//  ---------+------------------------------------------------------
//  IDLE     | bus free, waiting for START
//  ADDR     | shifting 7-bit address + R/W
//  ACK_ADDR | address matched, ACKing it
//  WR_PTR   | receiving the pointer byte, then ACK
//  WR_BYTE  | receiving data bytes into file[ptr++], ACK each
//  RD_BYTE  | driving file[ptr] MSB first
//  RD_ACK   | sampling master ACK/NACK on the 9th clock
//  IGNORE   | not addressed or NACKed, wait for START/STOP
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
    parameter int         DEPTH      = DEPTH_DEFAULT,
    parameter int         PTR_W      = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    input  logic             ld_we,
    input  logic [PTR_W-1:0] ld_addr,
    input  logic [7:0]       ld_data,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e       state_q, state_d;
    ack_phase_e       ap_q, ap_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rx_byte;
    logic [7:0] rd_word;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_word = mem_q[ptr_q];

    // Register file: I2C commits (registered strobe) take priority over preload.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_strobe_q && (wr_addr_q == PTR_W'(i))) begin
                mem_q[i] <= wr_data_q;
            end else if (ld_we && (ld_addr == PTR_W'(i))) begin
                mem_q[i] <= ld_data;
            end
        end
    end

    // FSM and datapath state register; reset releases SDA without a clock.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            ap_q        <= AP_NONE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ap_q        <= ap_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Next-state logic; START/STOP override whatever the FSM is doing.
    always_comb begin
        state_d     = state_q;
        ap_d        = ap_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (start_det) begin
            state_d  = ADDR;
            ap_d     = AP_NONE;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            ap_d     = AP_NONE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                ap_d    = AP_ARM;
                                state_d = ACK_ADDR;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end

                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (ap_q == AP_ARM) begin
                            sda_oe_d = 1'b1;
                            ap_d     = AP_DRIVE;
                        end else begin
                            ap_d     = AP_NONE;
                            bitcnt_d = '0;
                            if (rw_q) begin
                                // The ACK release fall is also the first data fall.
                                state_d  = RD_BYTE;
                                shift_d  = rd_word;
                                sda_oe_d = ~rd_word[7];
                            end else begin
                                state_d  = WR_PTR;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                WR_PTR, WR_BYTE: begin
                    if (ap_q == AP_NONE) begin
                        if (scl_rise) begin
                            shift_d  = rx_byte;
                            bitcnt_d = bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                ap_d = AP_ARM;
                                if (state_q == WR_PTR) begin
                                    ptr_d = rx_byte[PTR_W-1:0];
                                end else begin
                                    wr_strobe_d = 1'b1;
                                    wr_addr_d   = ptr_q;
                                    wr_data_d   = rx_byte;
                                    ptr_d       = ptr_q + PTR_ONE;
                                end
                            end
                        end
                    end else if (scl_fall) begin
                        if (ap_q == AP_ARM) begin
                            sda_oe_d = 1'b1;
                            ap_d     = AP_DRIVE;
                        end else begin
                            sda_oe_d = 1'b0;
                            ap_d     = AP_NONE;
                            bitcnt_d = '0;
                            state_d  = WR_BYTE;
                        end
                    end
                end

                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + PTR_ONE;
                            bitcnt_d = '0;
                            ap_d     = AP_NONE;
                            state_d  = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end

                RD_ACK: begin
                    if (ap_q == AP_NONE) begin
                        if (scl_rise) begin
                            if (sda_s == ACK_BIT) begin
                                ap_d = AP_MACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        ap_d     = AP_NONE;
                        bitcnt_d = '0;
                        state_d  = RD_BYTE;
                        shift_d  = rd_word;
                        sda_oe_d = ~rd_word[7];
                    end
                end

                IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: an I2C master model drives the bus, and a
// transaction-level model (file array + pointer) predicts ACKs, read data,
// busy and the commit strobes.
module tb_i2c_slave_responder;

    localparam logic [6:0] SLV = 7'h10;
    localparam int         Q   = 5;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       ld_we = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       sda_oe, wr_strobe, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_mem [16];
    bit         m_known [16];
    logic [3:0] m_ptr = '0;
    wr_t        exp_q [$];
    wr_t        seen_q [$];
    logic [7:0] tx [8];
    logic [7:0] rx [8];

    logic win = 1'b0;
    logic oe_known = 1'b0, exp_oe = 1'b0, busy_known = 1'b0, exp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // Per-cycle comparison of outputs during SCL-high windows and of every commit strobe.
    task automatic checker_loop();
        wr_t e;
        forever begin
            @(posedge PCLK);
            #1;
            if (PRESETn) begin
                if (win && oe_known) check("sda_oe", 32'(sda_oe), 32'(exp_oe));
                if (win && busy_known) check("busy", 32'(busy), 32'(exp_busy));
                if (wr_strobe) begin
                    e.a = wr_addr;
                    e.d = wr_data;
                    seen_q.push_back(e);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_strobe: unexpected commit addr=%0d data=%0h", wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(wr_addr), 32'(e.a));
                        check("wr_data", 32'(wr_data), 32'(e.d));
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        m_ptr = '0;
        for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
    endtask

    task automatic ld(input logic [3:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we   = 1'b1;
        @(negedge PCLK);
        ld_we = 1'b0;
        m_mem[a]   = d;
        m_known[a] = 1'b1;
    endtask

    // One SCL clock: data set while low, expectations held for the high phase.
    task automatic bit_slot(input logic drv, input logic ok, input logic eo,
                            input logic bk, input logic eb, output logic rd);
        sda_m = drv;
        wait_n(Q);
        oe_known   = ok;
        exp_oe     = eo;
        busy_known = bk;
        exp_busy   = eb;
        scl_m = 1'b1;
        win   = 1'b1;
        wait_n(Q);
        rd = sda_bus;
        wait_n(Q);
        win   = 1'b0;
        scl_m = 1'b0;
        wait_n(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        wait_n(Q);
        scl_m = 1'b1;
        wait_n(Q);
        sda_m = 1'b0;
        wait_n(Q);
        scl_m = 1'b0;
        wait_n(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        wait_n(Q);
        scl_m = 1'b1;
        wait_n(Q);
        sda_m = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        check("busy_after_stop", 32'(busy), 32'd0);
        wait_n(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic acked, input logic is_addr);
        logic r;
        for (int i = 7; i >= 0; i--)
            bit_slot(b[i], 1'b1, 1'b0, !(is_addr && i == 0), is_addr ? 1'b0 : acked, r);
        bit_slot(1'b1, 1'b1, acked, 1'b1, acked, r);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic known, input logic nack,
                             output logic [7:0] got);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, known, ~exp[i], 1'b1, 1'b1, r);
            got[i] = r;
        end
        bit_slot(nack, 1'b1, 1'b0, !nack, 1'b1, r);
    endtask

    // Master write: tx[0] is the pointer, tx[1..n-1] are data bytes.
    task automatic xfer_write(input logic [6:0] a, input int n, input bit do_stop);
        logic m;
        wr_t  e;
        m = (a == SLV);
        start_cond();
        send_byte({a, 1'b0}, m, 1'b1);
        for (int k = 0; k < n; k++) begin
            if (m) begin
                if (k == 0) begin
                    m_ptr = tx[0][3:0];
                end else begin
                    e.a = m_ptr;
                    e.d = tx[k];
                    exp_q.push_back(e);
                    m_mem[m_ptr]   = tx[k];
                    m_known[m_ptr] = 1'b1;
                    m_ptr = m_ptr + 4'd1;
                end
            end
            send_byte(tx[k], m, 1'b0);
        end
        if (do_stop) stop_cond();
    endtask

    // Master read of n bytes from the current pointer; last byte NACKed.
    task automatic xfer_read(input int n);
        logic [7:0] g;
        start_cond();
        send_byte({SLV, 1'b1}, 1'b1, 1'b1);
        for (int k = 0; k < n; k++) begin
            recv_byte(m_mem[m_ptr], m_known[m_ptr], (k == n - 1), g);
            rx[k] = g;
            if (m_known[m_ptr]) check("rd_byte", 32'(g), 32'(m_mem[m_ptr]));
            m_ptr = m_ptr + 4'd1;
        end
        stop_cond();
    endtask

    initial begin
        logic [6:0] ra;
        int         nb;
        fork
            checker_loop();
        join_none

        model_reset();
        PRESETn = 1'b0;
        wait_n(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        PRESETn = 1'b1;
        wait_n(4);

        for (int i = 0; i < 16; i++) ld(4'(i), 8'($urandom_range(0, 255)));

        // Address-match write
        seen_q.delete();
        tx[0] = 8'h03; tx[1] = 8'hA5; tx[2] = 8'h5A;
        xfer_write(SLV, 3, 1'b1);
        check("wr_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("wr0_addr", 32'(seen_q[0].a), 32'd3);
            check("wr0_data", 32'(seen_q[0].d), 32'hA5);
            check("wr1_addr", 32'(seen_q[1].a), 32'd4);
            check("wr1_data", 32'(seen_q[1].d), 32'h5A);
        end

        // Address mismatch (0x22 on the wire)
        seen_q.delete();
        tx[0] = 8'h01;
        xfer_write(7'h11, 1, 1'b1);
        check("mismatch_no_strobe", 32'(seen_q.size()), 32'd0);

        // Read with repeated START
        ld(4'd7, 8'h3C);
        ld(4'd8, 8'hC3);
        tx[0] = 8'h07;
        xfer_write(SLV, 1, 1'b0);
        xfer_read(2);
        check("rd_lit0", 32'(rx[0]), 32'h3C);
        check("rd_lit1", 32'(rx[1]), 32'hC3);

        // Pointer wrap
        seen_q.delete();
        tx[0] = 8'h0F; tx[1] = 8'h11; tx[2] = 8'h22;
        xfer_write(SLV, 3, 1'b1);
        check("wrap_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("wrap_addr0", 32'(seen_q[0].a), 32'd15);
            check("wrap_addr1", 32'(seen_q[1].a), 32'd0);
        end
        tx[0] = 8'h0F;
        xfer_write(SLV, 1, 1'b0);
        xfer_read(2);
        check("wrap_rd0", 32'(rx[0]), 32'h11);
        check("wrap_rd1", 32'(rx[1]), 32'h22);

        // Randomized traffic
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0: ld(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                1: begin
                    ra = SLV;
                    if ($urandom_range(0, 3) == 0) begin
                        ra = 7'($urandom_range(0, 127));
                        if (ra == SLV) ra = ra ^ 7'h01;
                    end
                    nb = $urandom_range(1, 4);
                    for (int k = 0; k < nb; k++) tx[k] = 8'($urandom_range(0, 255));
                    xfer_write(ra, nb, 1'b1);
                end
                default: begin
                    tx[0] = 8'($urandom_range(0, 255));
                    xfer_write(SLV, 1, 1'b0);
                    xfer_read($urandom_range(1, 3));
                end
            endcase
        end

        // Reset in the middle of a read while SDA is pulled
        ld(4'd9, 8'h00);
        tx[0] = 8'h09;
        xfer_write(SLV, 1, 1'b0);
        start_cond();
        send_byte({SLV, 1'b1}, 1'b1, 1'b1);
        sda_m = 1'b1;
        wait_n(Q);
        scl_m = 1'b1;
        wait_n(2);
        check("oe_before_reset", 32'(sda_oe), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("oe_async_reset", 32'(sda_oe), 32'd0);
        check("busy_async_reset", 32'(busy), 32'd0);
        wait_n(3);
        PRESETn = 1'b1;
        model_reset();
        wait_n(Q);
        seen_q.delete();
        tx[0] = 8'h02; tx[1] = 8'h77;
        xfer_write(SLV, 2, 1'b1);
        check("post_reset_count", 32'(seen_q.size()), 32'd1);

        // Preload colliding with an I2C commit to the same index
        tx[0] = 8'h04; tx[1] = 8'h12;
        fork
            xfer_write(SLV, 2, 1'b1);
            begin
                int n;
                n = 0;
                while (!wr_strobe && n < 3000) begin
                    @(negedge PCLK);
                    n++;
                end
                if (!wr_strobe) begin
                    checks++;
                    errors++;
                    $display("FAIL collision_wait: no wr_strobe within %0d cycles", n);
                end else begin
                    ld_addr = 4'd4;
                    ld_data = 8'hFF;
                    ld_we   = 1'b1;
                    @(negedge PCLK);
                    ld_we = 1'b0;
                end
            end
        join
        tx[0] = 8'h04;
        xfer_write(SLV, 1, 1'b0);
        xfer_read(1);
        check("collision_rd", 32'(rx[0]), 32'h12);

        check("strobe_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
